// File: rtl/uart_cmd_rsp_if.sv
// Handshake bundle between the UART transceiver / command dispatcher and uart_cmd_rsp.
// The slave modport is the command/response block; master is the surrounding core.
interface uart_cmd_rsp_if;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CMD_W  = 24;

    logic                rx_rdy;
    logic [BYTE_W-1:0]   rx_data;
    logic                clr_rx_rdy;
    logic [CMD_W-1:0]    cmd;
    logic                cmd_rdy;
    logic                clr_cmd_rdy;
    logic                timeout_err;
    logic                send_resp;
    logic [BYTE_W-1:0]   resp_data;
    logic                trmt;
    logic [BYTE_W-1:0]   tx_data;
    logic                tx_done;
    logic                resp_sent;
    logic                tx_busy;

    modport slave (
        input  rx_rdy, rx_data, clr_cmd_rdy, send_resp, resp_data, tx_done,
        output clr_rx_rdy, cmd, cmd_rdy, timeout_err, trmt, tx_data, resp_sent, tx_busy
    );

    modport master (
        output rx_rdy, rx_data, clr_cmd_rdy, send_resp, resp_data, tx_done,
        input  clr_rx_rdy, cmd, cmd_rdy, timeout_err, trmt, tx_data, resp_sent, tx_busy
    );
endinterface

// File: rtl/uart_cmd_rsp.sv
// Device end of the 3-byte UART command protocol: frames received bytes into 24-bit
// commands with an inter-byte timeout, and forwards single response bytes to the transmitter.
module uart_cmd_rsp #(
    parameter int unsigned TO_CYCLES = 50000,
    parameter int unsigned TO_W      = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_cmd_rsp_if.slave bus
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CMD_W  = 24;

    typedef enum logic [1:0] {B0, B1, B2, HOLD} rx_state_e;
    typedef enum logic {TX_IDLE, TX_WAIT} tx_state_e;

    rx_state_e         rx_state, rx_next;
    logic              rx_rdy_q, rx_rdy_d;
    logic [TO_W-1:0]   to_cnt, to_cnt_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic              cmd_rdy_q, cmd_rdy_d;
    logic              clr_rx_q, clr_rx_d;
    logic              to_err_q, to_err_d;
    logic              accept_c;
    logic              to_hit_c;

    tx_state_e         tx_state, tx_next;
    logic              tx_done_q;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              trmt_q, trmt_d;
    logic              busy_q, busy_d;
    logic              sent_q, sent_d;
    logic              done_edge_c;

    // A new byte is a rising edge of rx_rdy; a held level never re-captures.
    assign accept_c    = bus.rx_rdy & ~rx_rdy_q;
    assign to_hit_c    = (to_cnt == TO_W'(TO_CYCLES - 1));
    assign done_edge_c = bus.tx_done & ~tx_done_q;

    // Receive state register
    always_ff @(posedge clk) begin
        if (rst) rx_state <= B0;
        else     rx_state <= rx_next;
    end

    // Receive next-state; an accept in the terminal-count cycle beats the timeout
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            B0:      if (accept_c) rx_next = B1;
            B1: begin
                if (accept_c)      rx_next = B2;
                else if (to_hit_c) rx_next = B0;
            end
            B2: begin
                if (accept_c)      rx_next = HOLD;
                else if (to_hit_c) rx_next = B0;
            end
            HOLD:    if (bus.clr_cmd_rdy) rx_next = B0;
            default: rx_next = B0;
        endcase
    end

    // Receive datapath next values
    always_comb begin
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        clr_rx_d  = 1'b0;
        to_err_d  = 1'b0;
        to_cnt_d  = to_cnt;
        rx_rdy_d  = bus.rx_rdy;
        case (rx_state)
            B0: begin
                to_cnt_d = '0;
                if (accept_c) begin
                    cmd_d[23:16] = bus.rx_data;
                    clr_rx_d     = 1'b1;
                end
            end
            B1, B2: begin
                if (accept_c) begin
                    if (rx_state == B1) begin
                        cmd_d[15:8] = bus.rx_data;
                    end else begin
                        cmd_d[7:0] = bus.rx_data;
                        cmd_rdy_d  = 1'b1;
                    end
                    clr_rx_d = 1'b1;
                    to_cnt_d = '0;
                end else if (to_hit_c) begin
                    to_cnt_d = '0;
                    to_err_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt + TO_W'(1);
                end
            end
            HOLD: begin
                to_cnt_d = '0;
                // Forget the edge history so a byte left pending during HOLD is taken next
                if (bus.clr_cmd_rdy) begin
                    cmd_rdy_d = 1'b0;
                    rx_rdy_d  = 1'b0;
                end
            end
            default: to_cnt_d = '0;
        endcase
    end

    // Receive datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_rdy_q  <= 1'b0;
            to_cnt    <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
            clr_rx_q  <= 1'b0;
            to_err_q  <= 1'b0;
        end else begin
            rx_rdy_q  <= rx_rdy_d;
            to_cnt    <= to_cnt_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
            clr_rx_q  <= clr_rx_d;
            to_err_q  <= to_err_d;
        end
    end

    // Transmit state register
    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_next;
    end

    // Transmit next-state; requests while waiting are dropped, not queued
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE: if (bus.send_resp) tx_next = TX_WAIT;
            TX_WAIT: if (done_edge_c)   tx_next = TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    // Transmit datapath next values
    always_comb begin
        tx_data_d = tx_data_q;
        trmt_d    = 1'b0;
        busy_d    = busy_q;
        sent_d    = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (bus.send_resp) begin
                    tx_data_d = bus.resp_data;
                    trmt_d    = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            TX_WAIT: begin
                if (done_edge_c) begin
                    sent_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: busy_d = 1'b0;
        endcase
    end

    // Transmit datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_done_q <= 1'b0;
            tx_data_q <= '0;
            trmt_q    <= 1'b0;
            busy_q    <= 1'b0;
            sent_q    <= 1'b0;
        end else begin
            tx_done_q <= bus.tx_done;
            tx_data_q <= tx_data_d;
            trmt_q    <= trmt_d;
            busy_q    <= busy_d;
            sent_q    <= sent_d;
        end
    end

    assign bus.clr_rx_rdy  = clr_rx_q;
    assign bus.cmd         = cmd_q;
    assign bus.cmd_rdy     = cmd_rdy_q;
    assign bus.timeout_err = to_err_q;
    assign bus.trmt        = trmt_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.resp_sent   = sent_q;
    assign bus.tx_busy     = busy_q;
endmodule

// File: tb/tb_uart_cmd_rsp.sv
// Bench for uart_cmd_rsp: directed protocol scenarios plus randomized byte/response
// traffic checked against a byte-level framing and response model.
module tb_uart_cmd_rsp;
    localparam int unsigned TO = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_cmd_rsp_if bus();

    uart_cmd_rsp #(.TO_CYCLES(TO), .TO_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    longint cyc     = 0;
    int    n_clr    = 0;
    int    n_to     = 0;
    int    n_trmt   = 0;
    int    n_sent   = 0;

    // Byte-level model of command framing and response traffic
    int          m_idx      = 0;
    logic [23:0] m_part     = '0;
    longint      m_last     = 0;
    int          m_exp_to   = 0;
    logic [7:0]  m_tx       = '0;
    int          m_exp_trmt = 0;

    // Pulse counters sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.clr_rx_rdy)  n_clr++;
        if (bus.timeout_err) n_to++;
        if (bus.trmt)        n_trmt++;
        if (bus.resp_sent)   n_sent++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Returns 1 when this byte completes a command; a gap longer than TO drops the partial
    function automatic logic model_accept(input logic [7:0] b, input longint a);
        if (m_idx != 0 && a > m_last + longint'(TO)) begin
            m_idx = 0;
            m_exp_to++;
        end
        m_part = {m_part[15:0], b};
        m_idx++;
        m_last = a;
        if (m_idx == 3) begin
            m_idx = 0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap, input bit auto_clr);
        int   lat;
        logic done;
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.clr_rx_rdy && lat < 8);
        check("clr_rx_rdy_latency", 32'(lat), 32'd1);
        bus.rx_rdy = 1'b0;
        done = model_accept(b, cyc);
        check("timeout_count", 32'(n_to), 32'(m_exp_to));
        check("cmd_rdy", 32'(bus.cmd_rdy), 32'(done));
        if (done) begin
            check("cmd", 32'(bus.cmd), 32'(m_part));
            if (auto_clr) begin
                bus.clr_cmd_rdy = 1'b1;
                @(negedge clk);
                bus.clr_cmd_rdy = 1'b0;
                check("cmd_rdy_cleared", 32'(bus.cmd_rdy), 32'd0);
            end
        end
        repeat (gap) @(negedge clk);
    endtask

    task automatic tx_send(input logic [7:0] b, input bit dup, input int wait_cyc, input int done_len);
        bus.resp_data = b;
        bus.send_resp = 1'b1;
        @(negedge clk);
        bus.send_resp = 1'b0;
        m_tx = b;
        m_exp_trmt++;
        check("trmt_pulse", 32'(bus.trmt), 32'd1);
        check("tx_data", 32'(bus.tx_data), 32'(m_tx));
        check("tx_busy_set", 32'(bus.tx_busy), 32'd1);
        if (dup) begin
            bus.resp_data = ~b;
            bus.send_resp = 1'b1;
            @(negedge clk);
            bus.send_resp = 1'b0;
            check("busy_send_ignored_trmt", 32'(bus.trmt), 32'd0);
            check("busy_send_ignored_data", 32'(bus.tx_data), 32'(m_tx));
        end
        repeat (wait_cyc) @(negedge clk);
        check("no_early_resp_sent", 32'(bus.resp_sent), 32'd0);
        check("still_busy", 32'(bus.tx_busy), 32'd1);
        bus.tx_done = 1'b1;
        @(negedge clk);
        check("resp_sent", 32'(bus.resp_sent), 32'd1);
        check("tx_busy_clear", 32'(bus.tx_busy), 32'd0);
        for (int i = 0; i < done_len; i++) begin
            @(negedge clk);
            check("resp_sent_once", 32'(bus.resp_sent), 32'd0);
        end
        bus.tx_done = 1'b0;
        @(negedge clk);
        check("trmt_total", 32'(n_trmt), 32'(m_exp_trmt));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_clr_rx_rdy"},  32'(bus.clr_rx_rdy), 32'd0);
        check({tag, "_cmd"},         32'(bus.cmd), 32'd0);
        check({tag, "_cmd_rdy"},     32'(bus.cmd_rdy), 32'd0);
        check({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
        check({tag, "_trmt"},        32'(bus.trmt), 32'd0);
        check({tag, "_tx_data"},     32'(bus.tx_data), 32'd0);
        check({tag, "_resp_sent"},   32'(bus.resp_sent), 32'd0);
        check({tag, "_tx_busy"},     32'(bus.tx_busy), 32'd0);
    endtask

    task automatic rx_random();
        for (int i = 0; i < 45; i++) begin
            int r;
            int gap;
            r = int'($urandom_range(0, 9));
            if (r < 6)       gap = int'($urandom_range(1, 5));
            else if (r == 6) gap = TO - 1;
            else if (r == 7) gap = TO;
            else if (r == 8) gap = TO + 1;
            else             gap = TO + 4;
            send_byte(8'($urandom), gap, 1'b1);
        end
    endtask

    task automatic tx_random();
        for (int i = 0; i < 12; i++) begin
            repeat (int'($urandom_range(1, 8))) @(negedge clk);
            tx_send(8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int clr0;
        int to0;
        int n;
        int seen;
        logic done;

        rst             = 1'b1;
        bus.rx_rdy      = 1'b0;
        bus.rx_data     = '0;
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b0;
        bus.resp_data   = '0;
        bus.tx_done     = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic command, bytes 20 cycles apart
        clr0 = n_clr;
        send_byte(8'h02, 19, 1'b1);
        send_byte(8'h1C, 19, 1'b1);
        send_byte(8'h00, 2, 1'b1);
        check("three_clr_pulses", 32'(n_clr - clr0), 32'd3);

        // Byte arriving while the command is still held
        send_byte(8'h08, 2, 1'b1);
        send_byte(8'h2A, 2, 1'b1);
        send_byte(8'hAB, 0, 1'b0);
        clr0 = n_clr;
        bus.rx_data = 8'h09;
        bus.rx_rdy  = 1'b1;
        repeat (5) @(negedge clk);
        check("hold_no_clr", 32'(n_clr - clr0), 32'd0);
        check("hold_cmd", 32'(bus.cmd), 32'h082AAB);
        check("hold_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
        check("hold_release_rdy", 32'(bus.cmd_rdy), 32'd0);
        check("hold_release_cmd_kept", 32'(bus.cmd), 32'h082AAB);
        @(negedge clk);
        check("pending_byte_captured", 32'(bus.clr_rx_rdy), 32'd1);
        bus.rx_rdy = 1'b0;
        done = model_accept(8'h09, cyc);
        repeat (2) @(negedge clk);
        send_byte(8'h2A, 2, 1'b1);
        send_byte(8'h00, 2, 1'b0);
        check("resumed_cmd", 32'(bus.cmd), 32'h092A00);
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
        @(negedge clk);

        // Inter-byte timeout and resynchronisation
        to0 = n_to;
        send_byte(8'h01, 0, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.timeout_err && n < 2 * TO + 10);
        check("timeout_cycle", 32'(n), 32'(TO));
        check("timeout_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
        @(negedge clk);
        check("timeout_one_pulse", 32'(bus.timeout_err), 32'd0);
        repeat (3) @(negedge clk);
        check("timeout_pulse_count", 32'(n_to - to0), 32'd1);
        send_byte(8'h07, 2, 1'b1);
        send_byte(8'h00, 2, 1'b1);
        send_byte(8'h00, 2, 1'b1);

        // Held rx_rdy level captures once
        bus.rx_data = 8'h05;
        bus.rx_rdy  = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.clr_rx_rdy) begin
                seen++;
                if (seen == 1) done = model_accept(8'h05, cyc);
            end
        end
        bus.rx_rdy = 1'b0;
        check("held_level_one_capture", 32'(seen), 32'd1);
        check("held_byte0", 32'(bus.cmd[23:16]), 32'h05);
        check("held_no_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
        @(negedge clk);
        send_byte(8'h06, 2, 1'b1);
        send_byte(8'h07, 2, 1'b1);

        // Response path with an ignored request while busy
        tx_send(8'hA5, 1'b1, 3, 0);

        // Reset in the middle of a command and a transmit
        send_byte(8'h11, 2, 1'b1);
        send_byte(8'h22, 2, 1'b1);
        bus.resp_data = 8'h3C;
        bus.send_resp = 1'b1;
        @(negedge clk);
        bus.send_resp = 1'b0;
        m_exp_trmt++;
        check("pre_reset_busy", 32'(bus.tx_busy), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("mid_reset");
        rst   = 1'b0;
        m_idx = 0;
        m_tx  = '0;
        @(negedge clk);
        check("post_reset_tx_data", 32'(bus.tx_data), 32'(m_tx));
        send_byte(8'h03, 2, 1'b1);
        send_byte(8'h80, 2, 1'b1);
        send_byte(8'h00, 2, 1'b1);
        check("post_reset_cmd", 32'(bus.cmd), 32'h038000);

        // Randomized traffic on both paths at once
        fork
            rx_random();
            tx_random();
        join
        repeat (4) @(negedge clk);
        check("final_trmt_total", 32'(n_trmt), 32'(m_exp_trmt));
        check("final_timeouts", 32'(n_to), 32'(m_exp_to));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
